shifter_pipe: RTL and testbench

Parametrised, pipelined ARM-style barrel shifter with carry-out. It replaces the single-cycle combinational shifter in the execute path when the operand width grows or when timing closure needs the shift split across cycles. It implements full ARM shift semantics, including immediate-zero encodings and amounts of WIDTH or more. One operation is accepted per cycle under a valid/ready handshake, and a sideband tag is carried alongside each operation.

---
 rtl/shifter_pkg.sv | 11 +
 rtl/shifter_stage.sv | 78 +++++++
 rtl/shifter_pipe.sv | 192 +++++++++++++++++++
 tb/tb_shifter_pipe.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined ARM-style barrel shifter.
package shifter_pkg;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_type_t;

endpackage

// File: rtl/shifter_stage.sv
// One pipeline slot: conditional shift by a fixed power of two, then the payload register.
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int AMT_BITS = 5,
    parameter int TAG_W    = 4,
    parameter int STAGE    = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                advance,
    input  logic                in_valid,
    input  shift_type_t         in_type,
    input  logic [WIDTH-1:0]    in_data,
    input  logic [AMT_BITS-1:0] in_amt,
    input  logic                in_cout,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    output shift_type_t         out_type,
    output logic [WIDTH-1:0]    out_data,
    output logic [AMT_BITS-1:0] out_amt,
    output logic                out_cout,
    output logic [TAG_W-1:0]    out_tag
);

    localparam int SHIFT = 1 << STAGE;

    typedef struct packed {
        logic                valid;
        shift_type_t         sh_type;
        logic [WIDTH-1:0]    data;
        logic [AMT_BITS-1:0] amt;
        logic                cout;
        logic [TAG_W-1:0]    tag;
    } slot_t;

    slot_t            slot_d, slot_q;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        shifted = in_data;
        case (in_type)
            SH_LSL: shifted = in_data << SHIFT;
            SH_LSR: shifted = in_data >> SHIFT;
            SH_ASR: shifted = $unsigned($signed(in_data) >>> SHIFT);
            SH_ROR: shifted = {in_data[SHIFT-1:0], in_data[WIDTH-1:SHIFT]};
        endcase
    end

    always_comb begin
        slot_d = slot_q;
        if (advance) begin
            slot_d.valid   = in_valid;
            slot_d.sh_type = in_type;
            slot_d.data    = in_amt[STAGE] ? shifted : in_data;
            slot_d.amt     = in_amt;
            slot_d.cout    = in_cout;
            slot_d.tag     = in_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign out_valid = slot_q.valid;
    assign out_type  = slot_q.sh_type;
    assign out_data  = slot_q.data;
    assign out_amt   = slot_q.amt;
    assign out_cout  = slot_q.cout;
    assign out_tag   = slot_q.tag;

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter with carry-out: decode slot, log2(WIDTH) shift slots, output register.
// Define SHIFTER_RRX_EN to make immediate ROR #0 perform RRX.
module shifter_pipe
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT_W = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  shift_type_t      in_type,
    input  logic             in_imm,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [WIDTH-1:0] in_val,
    input  logic             in_cin,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_cout,
    output logic [TAG_W-1:0] out_tag
);

    localparam int L = $clog2(WIDTH);

    typedef struct packed {
        logic             valid;
        shift_type_t      sh_type;
        logic [WIDTH-1:0] data;
        logic [L-1:0]     amt;
        logic             cout;
        logic [TAG_W-1:0] tag;
    } slot_t;

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
        logic             cout;
        logic [TAG_W-1:0] tag;
    } out_t;

    slot_t            slot0_d, slot0_q;
    out_t             out_d, out_q;
    logic             advance;
    logic [AMT_W-1:0] amt_eff;
    logic [31:0]      a_wide;
    logic [L-1:0]     lo, lo_neg, lo_dec;
    logic [WIDTH-1:0] d_data;
    logic [L-1:0]     d_amt;
    logic             d_cout;

    assign advance  = out_ready | ~out_q.valid;
    assign in_ready = advance;

    // Out-of-range amounts and carry-out are resolved here; the shift slots only move data.
    always_comb begin
        amt_eff = in_imm ? AMT_W'(in_amt[L-1:0]) : in_amt;
        a_wide  = 32'(amt_eff);
        lo      = amt_eff[L-1:0];
        lo_neg  = -lo;
        lo_dec  = lo - L'(1);
        d_data  = in_val;
        d_amt   = '0;
        d_cout  = in_cin;
        if (amt_eff == '0) begin
            if (in_imm) begin
                case (in_type)
                    SH_LSR: begin
                        d_data = '0;
                        d_cout = in_val[WIDTH-1];
                    end
                    SH_ASR: begin
                        d_data = {WIDTH{in_val[WIDTH-1]}};
                        d_cout = in_val[WIDTH-1];
                    end
                    SH_ROR: begin
`ifdef SHIFTER_RRX_EN
                        d_data = {in_cin, in_val[WIDTH-1:1]};
                        d_cout = in_val[0];
`endif
                    end
                    default: ;
                endcase
            end
        end else begin
            case (in_type)
                SH_LSL: begin
                    if (a_wide < 32'(WIDTH)) begin
                        d_amt  = lo;
                        d_cout = in_val[lo_neg];
                    end else begin
                        d_data = '0;
                        d_cout = (a_wide == 32'(WIDTH)) ? in_val[0] : 1'b0;
                    end
                end
                SH_LSR: begin
                    if (a_wide < 32'(WIDTH)) begin
                        d_amt  = lo;
                        d_cout = in_val[lo_dec];
                    end else begin
                        d_data = '0;
                        d_cout = (a_wide == 32'(WIDTH)) ? in_val[WIDTH-1] : 1'b0;
                    end
                end
                SH_ASR: begin
                    if (a_wide < 32'(WIDTH)) begin
                        d_amt  = lo;
                        d_cout = in_val[lo_dec];
                    end else begin
                        d_data = {WIDTH{in_val[WIDTH-1]}};
                        d_cout = in_val[WIDTH-1];
                    end
                end
                SH_ROR: begin
                    d_amt  = lo;
                    d_cout = (lo == '0) ? in_val[WIDTH-1] : in_val[lo_dec];
                end
            endcase
        end
    end

    always_comb begin
        slot0_d = slot0_q;
        if (advance) begin
            slot0_d.valid   = in_valid;
            slot0_d.sh_type = in_type;
            slot0_d.data    = d_data;
            slot0_d.amt     = d_amt;
            slot0_d.cout    = d_cout;
            slot0_d.tag     = in_tag;
        end
    end

    logic             st_valid [L+1];
    shift_type_t      st_type  [L+1];
    logic [WIDTH-1:0] st_data  [L+1];
    logic [L-1:0]     st_amt   [L+1];
    logic             st_cout  [L+1];
    logic [TAG_W-1:0] st_tag   [L+1];

    assign st_valid[0] = slot0_q.valid;
    assign st_type[0]  = slot0_q.sh_type;
    assign st_data[0]  = slot0_q.data;
    assign st_amt[0]   = slot0_q.amt;
    assign st_cout[0]  = slot0_q.cout;
    assign st_tag[0]   = slot0_q.tag;

    for (genvar k = 1; k <= L; k++) begin : g_stage
        shifter_stage #(
            .WIDTH(WIDTH), .AMT_BITS(L), .TAG_W(TAG_W), .STAGE(k - 1)
        ) u_stage (
            .clk(clk), .rst(rst), .advance(advance),
            .in_valid(st_valid[k-1]), .in_type(st_type[k-1]), .in_data(st_data[k-1]),
            .in_amt(st_amt[k-1]), .in_cout(st_cout[k-1]), .in_tag(st_tag[k-1]),
            .out_valid(st_valid[k]), .out_type(st_type[k]), .out_data(st_data[k]),
            .out_amt(st_amt[k]), .out_cout(st_cout[k]), .out_tag(st_tag[k])
        );
    end

    // Type and amount are spent once the last shift slot has been applied.
    logic unused_tail;
    assign unused_tail = ^{st_type[L], st_amt[L]};

    always_comb begin
        out_d = out_q;
        if (advance) begin
            out_d.valid = st_valid[L];
            out_d.data  = st_data[L];
            out_d.cout  = st_cout[L];
            out_d.tag   = st_tag[L];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot0_q <= '0;
            out_q   <= '0;
        end else begin
            slot0_q <= slot0_d;
            out_q   <= out_d;
        end
    end

    assign out_valid = out_q.valid;
    assign out_data  = out_q.data;
    assign out_cout  = out_q.cout;
    assign out_tag   = out_q.tag;

endmodule

// File: tb/tb_shifter_pipe.sv
// Directed vector bench for shifter_pipe (WIDTH=32): table of shifts plus stall and reset sequences.
module tb_shifter_pipe;
    import shifter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    shift_type_t in_type;
    logic        in_imm;
    logic [7:0]  in_amt;
    logic [31:0] in_val;
    logic        in_cin;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_cout;
    logic [3:0]  out_tag;

    int n_vec  = 0;
    int n_miss = 0;

    shifter_pipe #(.WIDTH(32), .AMT_W(8), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type), .in_imm(in_imm),
        .in_amt(in_amt), .in_val(in_val), .in_cin(in_cin), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_cout(out_cout), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        shift_type_t sh;
        logic        imm;
        logic [7:0]  amt;
        logic [31:0] val;
        logic        cin;
        logic [31:0] exp_data;
        logic        exp_cout;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one operation and hold it until the edge that accepts it.
    task automatic applyStimulus(input shift_type_t sh, input logic imm, input logic [7:0] amt,
                                 input logic [31:0] val, input logic cin, input logic [3:0] tag);
        bit acc = 0;
        in_valid = 1'b1;
        in_type  = sh;
        in_imm   = imm;
        in_amt   = amt;
        in_val   = val;
        in_cin   = cin;
        in_tag   = tag;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!acc) checkOutput("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic waitResult(input string name, input logic [31:0] exp_data,
                              input logic exp_cout, input logic [3:0] exp_tag);
        int lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        checkOutput({name, "_latency"}, 64'(lat), 64'd6);
        checkOutput({name, "_data"}, 64'(out_data), 64'(exp_data));
        checkOutput({name, "_cout"}, 64'(out_cout), 64'(exp_cout));
        checkOutput({name, "_tag"}, 64'(out_tag), 64'(exp_tag));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_sent;
        int n_recv;
        bit stall_prev;
        logic [31:0] hold_data;
        logic [3:0]  hold_tag;
        logic        hold_cout;
        logic [31:0] exp_d;

        vecs[0]  = '{SH_LSL, 1'b0, 8'd4,   32'h1000_0001, 1'b0, 32'h0000_0010, 1'b1};
        vecs[1]  = '{SH_LSR, 1'b1, 8'd0,   32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
        vecs[2]  = '{SH_ASR, 1'b0, 8'd40,  32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1};
        vecs[3]  = '{SH_ROR, 1'b0, 8'd32,  32'h8000_0001, 1'b0, 32'h8000_0001, 1'b1};
`ifdef SHIFTER_RRX_EN
        vecs[4]  = '{SH_ROR, 1'b1, 8'd0,   32'h0000_0003, 1'b1, 32'h8000_0001, 1'b1};
`else
        vecs[4]  = '{SH_ROR, 1'b1, 8'd0,   32'h0000_0003, 1'b1, 32'h0000_0003, 1'b1};
`endif
        vecs[5]  = '{SH_LSL, 1'b1, 8'd0,   32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1};
        vecs[6]  = '{SH_LSL, 1'b0, 8'd32,  32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
        vecs[7]  = '{SH_LSL, 1'b0, 8'd33,  32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0};
        vecs[8]  = '{SH_LSR, 1'b0, 8'd8,   32'h1234_5680, 1'b0, 32'h0012_3456, 1'b1};
        vecs[9]  = '{SH_LSR, 1'b0, 8'd32,  32'h7FFF_FFFF, 1'b1, 32'h0000_0000, 1'b0};
        vecs[10] = '{SH_ASR, 1'b0, 8'd4,   32'h8000_0018, 1'b0, 32'hF800_0001, 1'b1};
        vecs[11] = '{SH_ROR, 1'b0, 8'd8,   32'h1234_5678, 1'b1, 32'h7812_3456, 1'b0};
        vecs[12] = '{SH_ROR, 1'b0, 8'd36,  32'h0000_000F, 1'b0, 32'hF000_0000, 1'b1};
        vecs[13] = '{SH_ASR, 1'b0, 8'd0,   32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0};
        vecs[14] = '{SH_ASR, 1'b1, 8'd0,   32'h4000_0000, 1'b1, 32'h0000_0000, 1'b0};
        vecs[15] = '{SH_LSR, 1'b0, 8'd255, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0};
        vecs[16] = '{SH_LSL, 1'b1, 8'h21,  32'h8000_0001, 1'b0, 32'h0000_0002, 1'b1};
        vecs[17] = '{SH_ASR, 1'b0, 8'd31,  32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_type   = SH_LSL;
        in_imm    = 1'b0;
        in_amt    = '0;
        in_val    = '0;
        in_cin    = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_out_data", 64'(out_data), 64'd0);
        checkOutput("reset_out_cout", 64'(out_cout), 64'd0);
        checkOutput("reset_out_tag", 64'(out_tag), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].sh, vecs[i].imm, vecs[i].amt, vecs[i].val, vecs[i].cin, 4'(i));
            waitResult($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_cout, 4'(i));
        end

        // Streaming with a 3-cycle consumer stall in the middle.
        n_sent     = 0;
        n_recv     = 0;
        stall_prev = 0;
        hold_data  = '0;
        hold_tag   = '0;
        hold_cout  = 1'b0;
        for (int cyc = 0; cyc < 60 && n_recv < 8; cyc++) begin
            in_valid  = (n_sent < 8);
            in_type   = SH_LSL;
            in_imm    = 1'b0;
            in_amt    = 8'(n_sent);
            in_val    = 32'h8000_0001;
            in_cin    = 1'b0;
            in_tag    = 4'(n_sent);
            out_ready = !(cyc >= 9 && cyc < 12);
            @(negedge clk);
            checkOutput("stream_in_ready", 64'(in_ready), 64'(out_ready));
            if (!out_ready) checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
            if (stall_prev) begin
                checkOutput("stall_hold_data", 64'(out_data), 64'(hold_data));
                checkOutput("stall_hold_tag", 64'(out_tag), 64'(hold_tag));
                checkOutput("stall_hold_cout", 64'(out_cout), 64'(hold_cout));
            end
            if (out_valid && out_ready) begin
                exp_d = 32'h8000_0001 << n_recv;
                checkOutput("stream_tag", 64'(out_tag), 64'(n_recv));
                checkOutput("stream_data", 64'(out_data), 64'(exp_d));
                checkOutput("stream_cout", 64'(out_cout), 64'(n_recv == 1));
                n_recv++;
            end
            if (in_valid && in_ready) n_sent++;
            stall_prev = out_valid && !out_ready;
            hold_data  = out_data;
            hold_tag   = out_tag;
            hold_cout  = out_cout;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput("stream_sent", 64'(n_sent), 64'd8);
        checkOutput("stream_recv", 64'(n_recv), 64'd8);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checkOutput("stream_no_dup", 64'(out_valid), 64'd0);
            @(posedge clk);
            #1;
        end

        // Four operations in flight, then a one-cycle reset.
        for (int t = 0; t < 4; t++) begin
            in_valid = 1'b1;
            in_type  = SH_ROR;
            in_imm   = 1'b0;
            in_amt   = 8'(t + 1);
            in_val   = 32'hA5A5_0000 | 32'(t);
            in_cin   = 1'b0;
            in_tag   = 4'(t + 4);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_out_data", 64'(out_data), 64'd0);
        checkOutput("midrst_out_tag", 64'(out_tag), 64'd0);
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
        for (int c = 0; c < 10; c++) begin
            checkOutput("midrst_no_valid", 64'(out_valid), 64'd0);
            @(posedge clk);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        applyStimulus(SH_LSR, 1'b0, 8'd4, 32'hF000_000F, 1'b0, 4'd9);
        waitResult("post_reset", 32'h0F00_0000, 1'b1, 4'd9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
